// File: rtl/fetch_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl_pkg
//   Shared definitions for the fetch-stage hazard controller and its helpers:
//   the controller state type, the width of the boot/redirect down-counter
//   and the hardwired-zero register index.
// -----------------------------------------------------------------------------
package fetch_hazard_ctrl_pkg;

  // Width of the boot / redirect down-counter (holds up to 15).
  localparam int CNT_W = 4;

  // Register r0 is hardwired to zero, so a load into it never creates a hazard.
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

endpackage : fetch_hazard_ctrl_pkg

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard comparator. Flags the case where the
//   load in ID/EX writes a register that the instruction in IF/ID reads, so
//   the consumer must wait one cycle for the loaded value.
//
// Ports:
//   id_ex_memread  in  1  instruction in ID/EX is a load
//   id_ex_rt       in  5  load destination register
//   if_id_rs       in  5  source register 1 of the instruction in IF/ID
//   if_id_rt       in  5  source register 2 of the instruction in IF/ID
//   hazard         out 1  load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import fetch_hazard_ctrl_pkg::*;
(
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       hazard
);

  logic dest_valid;
  logic src_match;

  // A load targeting r0 produces nothing a consumer could depend on.
  assign dest_valid = id_ex_memread && (id_ex_rt != ZERO_REG);
  assign src_match  = (id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt);
  assign hazard     = dest_valid && src_match;

endmodule : load_use_detect

// File: rtl/fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl
//   Pipeline control unit that sequences the instruction-fetch stage. It holds
//   the front end frozen while the instruction memory primes after reset,
//   inserts one bubble on a load-use hazard, freezes on external stall
//   requests, and on a taken branch redirects the PC and squashes the
//   wrong-path instructions, keeping IF/ID flushed for the extra latency of
//   the synchronous instruction memory.
//
//   Outputs are combinational from the registered state and the current
//   inputs; state and the down-counter are the only control registers.
//
// Parameters:
//   BOOT_CYCLES  cycles PC and IF/ID stay frozen after reset release (1..15)
//   IMEM_LAT     extra cycles of IF/ID flush after a redirect (0..7)
//
// Ports:
//   CLK           in  1   clock, rising edge
//   RST           in  1   synchronous, active-high reset
//   BRANCH_TAKEN  in  1   taken branch resolved in EX/MEM this cycle
//   ID_EX_MEMREAD in  1   instruction in ID/EX is a load
//   ID_EX_RT      in  5   load destination register
//   IF_ID_RS      in  5   source register 1 of the instruction in IF/ID
//   IF_ID_RT      in  5   source register 2 of the instruction in IF/ID
//   STALL_REQ     in  1   external freeze request
//   PC_WRITE      out 1   PC register enable
//   IFIDWrite     out 1   IF/ID register enable
//   BRANCH        out 1   next-PC mux select (1 = EX_MEM_NPC)
//   IF_ID_FLUSH   out 1   zero IF/ID at next edge
//   ID_EX_FLUSH   out 1   bubble ID/EX control at next edge
//   EX_MEM_FLUSH  out 1   zero EX/MEM control at next edge
//   BUSY          out 1   controller not in RUN
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   STALL_CNT     out 32  cycles in RUN with PC_WRITE low
//   FLUSH_CNT     out 32  redirects taken
//   BUBBLE_CNT    out 32  load-use bubbles inserted
//   All three saturate at all-ones and clear on RST.
// -----------------------------------------------------------------------------
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int IMEM_LAT    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BRANCH_TAKEN,
  input  logic        ID_EX_MEMREAD,
  input  logic [4:0]  ID_EX_RT,
  input  logic [4:0]  IF_ID_RS,
  input  logic [4:0]  IF_ID_RT,
  input  logic        STALL_REQ,
  output logic        PC_WRITE,
  output logic        IFIDWrite,
  output logic        BRANCH,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
`ifdef FETCH_PERF_CNT_EN
  output logic        BUSY,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT,
  output logic [31:0] BUBBLE_CNT
`else
  output logic        BUSY
`endif
);

  localparam logic [CNT_W-1:0] BOOT_INIT  = CNT_W'(BOOT_CYCLES - 1);
  // Unused when IMEM_LAT is 0: the controller then never enters REDIRECT.
  localparam logic [CNT_W-1:0] REDIR_INIT = (IMEM_LAT > 0) ? CNT_W'(IMEM_LAT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .id_ex_memread (ID_EX_MEMREAD),
    .id_ex_rt      (ID_EX_RT),
    .if_id_rs      (IF_ID_RS),
    .if_id_rt      (IF_ID_RT),
    .hazard        (hazard)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_WRITE     = 1'b0;
    IFIDWrite    = 1'b0;
    BRANCH       = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    BUSY         = 1'b1;

    unique case (state_q)
      ST_BOOT: begin
        // Instruction memory is priming: hold PC and keep a NOP in IF/ID.
        // Branches, stalls and hazards are meaningless here and ignored.
        IF_ID_FLUSH = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RUN: begin
        BUSY = 1'b0;
        if (BRANCH_TAKEN) begin
          // Redirect wins over everything: the instructions being stalled
          // are on the wrong path and get squashed anyway.
          BRANCH       = 1'b1;
          PC_WRITE     = 1'b1;
          IFIDWrite    = 1'b1;
          IF_ID_FLUSH  = 1'b1;
          ID_EX_FLUSH  = 1'b1;
          EX_MEM_FLUSH = 1'b1;
          if (IMEM_LAT > 0) begin
            state_d = ST_REDIRECT;
            cnt_d   = REDIR_INIT;
          end
        end else if (STALL_REQ) begin
          // Whole front end holds; nothing is flushed.
        end else if (hazard) begin
          // Hold PC and IF/ID for one cycle and let a bubble into ID/EX. The
          // load moves on next cycle, so the hazard clears on its own.
          ID_EX_FLUSH = 1'b1;
        end else begin
          PC_WRITE  = 1'b1;
          IFIDWrite = 1'b1;
        end
      end

      ST_REDIRECT: begin
        // Memory output is still stale from the old PC: keep flushing IF/ID.
        // EX/MEM is already squashed so a new branch cannot be real, and
        // IF/ID holds a NOP so there is nothing to check for hazards.
        IFIDWrite   = 1'b1;
        IF_ID_FLUSH = 1'b1;
        if (!STALL_REQ) begin
          PC_WRITE = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
        cnt_d   = BOOT_INIT;
      end
    endcase

    // Reset overrides the decode so the pipeline is squashed while held.
    if (RST) begin
      PC_WRITE     = 1'b0;
      IFIDWrite    = 1'b0;
      BRANCH       = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      BUSY         = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or block order.
    if (RST) begin
      state_q <= ST_BOOT;
      cnt_q   <= BOOT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        in_run;

  assign in_run = (state_q == ST_RUN) && !RST;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (in_run && !PC_WRITE && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (in_run && BRANCH_TAKEN && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    // A bubble is only inserted when the hazard is the winning condition.
    if (in_run && !BRANCH_TAKEN && !STALL_REQ && hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign STALL_CNT  = stall_cnt_q;
  assign FLUSH_CNT  = flush_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`endif

endmodule : fetch_hazard_ctrl
